// File: rtl/des_round_sequencer.sv
// Purpose: iterates the 16 DES Feistel rounds on one block, with an external round function.
// Latency: 16 ROUND cycles; out_valid rises 16 edges after the accepting edge.
// Backpressure: a result is held in DONE until out_ready; requests are accepted only in IDLE.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        request handshake; in_decrypt, in_l, in_r, in_c, in_d sampled on accept
//   f_r, f_cd, f_in          current R and {C,D} to the external f/PC-2 logic, and its result
//   round_idx, busy          round 1..16 while iterating (0 otherwise), ROUND-state flag
//   out_valid/out_ready      result handshake; out_data = {R16, L16}
module des_round_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic [27:0] in_c,
  input  logic [27:0] in_d,
  output logic [31:0] f_r,
  output logic [55:0] f_cd,
  input  logic [31:0] f_in,
  output logic [4:0]  round_idx,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  round_q, round_d;
  logic        mode_q, mode_d;

  // Rotation applied when stepping into round k. Decrypt walks the encrypt
  // schedule backwards, so its amount for round k is the encrypt amount of
  // round 18-k; round 1 of decrypt uses C16/D16, which equal C0/D0.
  function automatic logic [1:0] shift_amt(input logic [4:0] k, input logic dec);
    logic single;
    single = (k == 5'd2) || (k == 5'd9) || (k == 5'd16);
    if (k == 5'd1)
      shift_amt = dec ? 2'd0 : 2'd1;
    else
      shift_amt = single ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl28 = {x[26:0], x[27]};
      2'd2:    rotl28 = {x[25:0], x[27:26]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr28 = {x[0], x[27:1]};
      2'd2:    rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

  always_comb begin
    logic [1:0] amt;
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    amt     = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          l_d     = in_l;
          r_d     = in_r;
          mode_d  = in_decrypt;
          round_d = 5'd1;
          amt     = shift_amt(5'd1, in_decrypt);
          c_d     = rotl28(in_c, amt);
          d_d     = rotl28(in_d, amt);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_in;
        if (round_q == 5'd16) begin
          // Key already sits at its round-16 value; leave it alone.
          state_d = S_DONE;
        end else begin
          round_d = round_q + 5'd1;
          amt     = shift_amt(round_q + 5'd1, mode_q);
          c_d     = mode_q ? rotr28(c_q, amt) : rotl28(c_q, amt);
          d_d     = mode_q ? rotr28(d_q, amt) : rotl28(d_q, amt);
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      l_q     <= 32'd0;
      r_q     <= 32'd0;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      round_q <= 5'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ROUND);
  assign out_valid = (state_q == S_DONE);
  // The counter keeps its last value after DONE; only expose it while iterating.
  assign round_idx = busy ? round_q : 5'd0;
  assign f_r       = r_q;
  assign f_cd      = {c_q, d_q};
  // Final Feistel swap: the pre-output block is {R16, L16}.
  assign out_data  = {r_q, l_q};

endmodule

// File: tb/tb_des_round_sequencer.sv
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_decrypt = 1'b0;
  logic [31:0] in_l = '0;
  logic [31:0] in_r = '0;
  logic [27:0] in_c = '0;
  logic [27:0] in_d = '0;
  logic [31:0] f_r;
  logic [55:0] f_cd;
  logic [31:0] f_in;
  logic [4:0]  round_idx;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  logic        fz_mode = 1'b0;
  logic [31:0] junk = 32'hDEADBEEF;
  logic [55:0] cd_tr [40];
  logic [4:0]  ridx_tr [40];

  des_round_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_l(in_l), .in_r(in_r), .in_c(in_c), .in_d(in_d),
    .f_r(f_r), .f_cd(f_cd), .f_in(f_in),
    .round_idx(round_idx), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // ---------------- golden DES pieces ----------------
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] t;
    logic [31:0] s_out, y;
    logic [5:0]  b;
    int          v;
    for (int i = 0; i < 48; i++) t[47-i] = r[32-E_T[i]];
    t = t ^ k;
    for (int s = 0; s < 8; s++) begin
      b = t[47-6*s -: 6];
      v = SBOX[s][{b[5], b[0]} * 16 + b[4:1]];
      s_out[31-4*s -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s_out[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < n % 28; i++) y = {y[26:0], y[27]};
    return y;
  endfunction

  // Key halves seen in round i: encrypt uses subkey i, decrypt uses subkey 17-i;
  // subkey j is C0/D0 rotated left by the sum of the first j schedule entries.
  function automatic logic [55:0] cd_for_round(input logic [27:0] c0, d0, input logic dec, input int i);
    int j, cum;
    j = dec ? 17 - i : i;
    cum = 0;
    for (int n = 0; n < j; n++) cum += SH_T[n];
    return {rol28(c0, cum), rol28(d0, cum)};
  endfunction

  function automatic logic [63:0] model_run(input logic dec, fz, input logic [31:0] l0, r0,
                                            input logic [27:0] c0, d0);
    logic [31:0] l, r, fv, t;
    l = l0;
    r = r0;
    for (int i = 1; i <= 16; i++) begin
      fv = fz ? 32'h0 : des_f(r, pc2(cd_for_round(c0, d0, dec, i)));
      t = l ^ fv;
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  // Round-function stand-in: real DES f during ROUND, garbage otherwise.
  always_comb begin
    if (!busy)        f_in = junk;
    else if (fz_mode) f_in = 32'h0;
    else              f_in = des_f(f_r, pc2(f_cd));
  end

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input string nm, input logic dec, input logic [31:0] l, r,
                           input logic [27:0] c, d);
    int n;
    in_decrypt = dec; in_l = l; in_r = r; in_c = c; in_d = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    check({nm, "_accept"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input bit noise, output int nbusy);
    nbusy = 0;
    while (!out_valid && nbusy < 40) begin
      cd_tr[nbusy] = f_cd;
      ridx_tr[nbusy] = round_idx;
      junk = $urandom;
      if (noise) begin
        in_valid = 1'b1; in_decrypt = 1'($urandom);
        in_l = $urandom; in_r = $urandom; in_c = 28'($urandom); in_d = 28'($urandom);
      end
      tick();
      nbusy++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic dec, fz, input logic [31:0] l, r,
                       input logic [27:0] c, d, input bit noise, input int dly,
                       output logic [63:0] res);
    int nb, bad;
    fz_mode = fz;
    start_req(nm, dec, l, r, c, d);
    wait_done(noise, nb);
    check({nm, "_busy_cycles"}, 64'(nb), 64'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (cd_tr[i] !== cd_for_round(c, d, dec, i + 1)) bad++;
      if (ridx_tr[i] !== 5'(i + 1)) bad++;
    end
    check({nm, "_round_trace_errs"}, 64'(bad), 64'd0);
    res = out_data;
    check({nm, "_out_data"}, res, model_run(dec, fz, l, r, c, d));
    bad = 0;
    for (int i = 0; i < dly; i++) begin
      junk = $urandom;
      tick();
      if (out_data !== res || !out_valid || in_ready) bad++;
    end
    if (dly > 0) check({nm, "_hold_errs"}, 64'(bad), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_idle_after"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    bit          full;
    bit          dec;
    bit          fz;
    logic [63:0] blk;
    logic [63:0] key;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    logic [63:0] res, od, b;
    logic [55:0] cd;
    logic [31:0] l, r;
    logic [27:0] c, d;
    int          bad, nb;

    tbl[0] = '{0, 0, 1, 64'h0123456789ABCDEF, 64'h0, 64'h89ABCDEF01234567};
    tbl[1] = '{0, 1, 1, 64'h0123456789ABCDEF, 64'h00ABCDEF12345678, 64'h89ABCDEF01234567};
    tbl[2] = '{1, 0, 0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405};
    tbl[3] = '{1, 1, 0, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF};
    tbl[4] = '{1, 0, 0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0000000000000000};
    tbl[5] = '{1, 1, 0, 64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787};

    // Reset values
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_f_r", 64'(f_r), 64'd0);
    check("rst_f_cd", 64'(f_cd), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].full) begin
        b = ip64(tbl[i].blk);
        cd = pc1(tbl[i].key);
      end else begin
        b = tbl[i].blk;
        cd = tbl[i].key[55:0];
      end
      do_op($sformatf("tbl%0d", i), tbl[i].dec, tbl[i].fz, b[63:32], b[31:0],
            cd[55:28], cd[27:0], 1'b0, 0, res);
      check($sformatf("tbl%0d_result", i), tbl[i].full ? fp64(res) : res, tbl[i].exp);
    end

    // Key-half trace: encrypt then decrypt starting from C0 = 1
    do_op("enc_c1", 1'b0, 1'b0, $urandom, $urandom, 28'h0000001, 28'($urandom), 1'b0, 0, res);
    check("enc_c1_r1", 64'(cd_tr[0][55:28]), 64'h0000002);
    check("enc_c1_r2", 64'(cd_tr[1][55:28]), 64'h0000004);
    check("enc_c1_r3", 64'(cd_tr[2][55:28]), 64'h0000010);
    check("enc_c1_r16", 64'(cd_tr[15][55:28]), 64'h0000001);
    do_op("dec_c1", 1'b1, 1'b0, $urandom, $urandom, 28'h0000001, 28'($urandom), 1'b0, 0, res);
    check("dec_c1_r1", 64'(cd_tr[0][55:28]), 64'h0000001);
    check("dec_c1_r2", 64'(cd_tr[1][55:28]), 64'h8000000);
    check("dec_c1_r3", 64'(cd_tr[2][55:28]), 64'h2000000);

    // Output backpressure with a follow-on request held the whole time
    fz_mode = 1'b0;
    l = $urandom; r = $urandom; c = 28'($urandom); d = 28'($urandom);
    start_req("bp1", 1'b0, l, r, c, d);
    wait_done(1'b0, nb);
    od = out_data;
    check("bp1_out_data", od, model_run(1'b0, 1'b0, l, r, c, d));
    l = $urandom; r = $urandom; c = 28'($urandom); d = 28'($urandom);
    in_decrypt = 1'b1; in_l = l; in_r = r; in_c = c; in_d = d; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      junk = $urandom;
      tick();
      if (out_data !== od || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("bp_hold_errs", 64'(bad), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_entered", 64'({in_ready, busy, out_valid}), 64'b100);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", 64'({busy, round_idx}), 64'({1'b1, 5'd1}));
    wait_done(1'b0, nb);
    check("bp2_busy_cycles", 64'(nb), 64'd16);
    check("bp2_out_data", out_data, model_run(1'b1, 1'b0, l, r, c, d));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of round 7, with a request pending during reset
    start_req("abort", 1'b0, $urandom, $urandom, 28'($urandom), 28'($urandom));
    repeat (6) tick();
    check("abort_round7", 64'(round_idx), 64'd7);
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick();
    check("abort_reset_outs", {32'(f_r), 5'(round_idx), in_ready, out_valid, busy},
          {32'd0, 5'd0, 1'b1, 1'b0, 1'b0});
    check("abort_reset_cd_data", {8'd0, f_cd} | out_data, 64'd0);
    tick();
    check("abort_rst_priority", 64'(busy), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || !in_ready) bad++;
    end
    check("abort_no_result", 64'(bad), 64'd0);
    do_op("after_abort", 1'b0, 1'b0, $urandom, $urandom, 28'($urandom), 28'($urandom), 1'b0, 0, res);

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("rnd%0d", i), 1'($urandom), 1'b0, $urandom, $urandom,
            28'($urandom), 28'($urandom), 1'(i % 2), int'($urandom_range(0, 3)), res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
